// File: rtl/matmul_ctrl.sv
// matmul_ctrl - sequencing controller for a MAC-based matrix multiplier.
//
// Computes C = A x B with A (d0 x d1) and B (d1 x d2), both row-major.
// For each result element (i,j), in row-major order, it:
//   - clears the accumulator,
//   - streams d1 A/B buffer reads,
//   - waits for the final accumulate,
//   - pulses a result write.
// Addresses come from base registers and incrementers only.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   start               begin a multiplication (honoured only in IDLE)
//   d0, d1, d2          matrix dimensions, sampled on the accepted start cycle
//   loaddim             datapath dimension-register load strobe
//   init0reg            accumulator clear
//   ldreg               accumulator load enable (abufread delayed one cycle)
//   abufread, bbufread  A/B buffer read enables
//   aadr, badr          A/B read addresses (i*d1+k, k*d2+j)
//   res_we, res_adr     result write enable / address (i*d2+j)
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   err                 dimensions exceed the address space; sticky until next start
//
// All outputs are registered. Strobes are decoded from the next state, so
// they line up with the state register. The address width m must not
// exceed n.
module matmul_ctrl #(
  parameter int unsigned n = 8,
  parameter int unsigned m = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  input  logic [n-1:0] d2,
  output logic         loaddim,
  output logic         init0reg,
  output logic         ldreg,
  output logic         abufread,
  output logic         bbufread,
  output logic [m-1:0] aadr,
  output logic [m-1:0] badr,
  output logic         res_we,
  output logic [m-1:0] res_adr,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOADDIM = 3'd1,
    S_CHECK   = 3'd2,
    S_CLEAR   = 3'd3,
    S_MAC     = 3'd4,
    S_DRAIN   = 3'd5,
    S_WRITE   = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  // Largest legal product of two dimensions: the full m-bit address space.
  localparam logic [2*n-1:0] ADDR_SPACE = {{(2*n-1){1'b0}}, 1'b1} << m;
  localparam logic [n:0]     ONE_W      = {{n{1'b0}}, 1'b1};
  localparam logic [n-1:0]   ONE_N      = {{(n-1){1'b0}}, 1'b1};
  localparam logic [m-1:0]   ONE_M      = {{(m-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [n-1:0]   d0_q, d1_q, d2_q;
  logic [n-1:0]   i_q, j_q, k_q;
  logic [m-1:0]   abase_q;
  logic [m-1:0]   aadr_q, badr_q, res_adr_q;
  logic           err_q;

  logic           loaddim_q, init0reg_q, ldreg_q, abufread_q, bbufread_q;
  logic           res_we_q, busy_q, done_q;
  logic           loaddim_d, init0reg_d, abufread_d, bbufread_d;
  logic           res_we_d, busy_d, done_d;

  logic [2*n-1:0] p01_s, p12_s, p02_s;
  logic           ovf_s, zero_s, last_k_s, more_col_s, more_row_s;
  logic [m-1:0]   d1_m_s, d2_m_s;

  // The products only feed the range check; addresses never use a multiplier.
  assign p01_s      = {{n{1'b0}}, d0_q} * {{n{1'b0}}, d1_q};
  assign p12_s      = {{n{1'b0}}, d1_q} * {{n{1'b0}}, d2_q};
  assign p02_s      = {{n{1'b0}}, d0_q} * {{n{1'b0}}, d2_q};
  assign ovf_s      = (p01_s > ADDR_SPACE) || (p12_s > ADDR_SPACE) || (p02_s > ADDR_SPACE);
  assign zero_s     = (d0_q == {n{1'b0}}) || (d2_q == {n{1'b0}});
  // Compare in n+1 bits so that "x == d-1" / "x < d-1" never wrap.
  assign last_k_s   = (({1'b0, k_q} + ONE_W) == {1'b0, d1_q});
  assign more_col_s = (({1'b0, j_q} + ONE_W) <  {1'b0, d2_q});
  assign more_row_s = (({1'b0, i_q} + ONE_W) <  {1'b0, d0_q});
  assign d1_m_s     = d1_q[m-1:0];
  assign d2_m_s     = d2_q[m-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOADDIM;
        else       state_d = S_IDLE;
      end
      S_LOADDIM: state_d = S_CHECK;
      S_CHECK: begin
        if (ovf_s || zero_s) state_d = S_DONE;
        else                 state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (d1_q == {n{1'b0}}) state_d = S_WRITE;
        else                   state_d = S_MAC;
      end
      S_MAC: begin
        if (last_k_s) state_d = S_DRAIN;
        else          state_d = S_MAC;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        if (more_col_s || more_row_s) state_d = S_CLEAR;
        else                          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, registered below to align with state_q.
  always_comb begin
    loaddim_d  = 1'b0;
    init0reg_d = 1'b0;
    abufread_d = 1'b0;
    bbufread_d = 1'b0;
    res_we_d   = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_LOADDIM: loaddim_d  = 1'b1;
      S_CLEAR:   init0reg_d = 1'b1;
      S_MAC: begin
        abufread_d = 1'b1;
        bbufread_d = 1'b1;
      end
      S_WRITE:   res_we_d   = 1'b1;
      S_DONE:    done_d     = 1'b1;
      default:   loaddim_d  = 1'b0;
    endcase
  end

  // Output strobe registers; ldreg trails abufread by the buffer read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaddim_q  <= 1'b0;
      init0reg_q <= 1'b0;
      ldreg_q    <= 1'b0;
      abufread_q <= 1'b0;
      bbufread_q <= 1'b0;
      res_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      loaddim_q  <= loaddim_d;
      init0reg_q <= init0reg_d;
      ldreg_q    <= abufread_q;
      abufread_q <= abufread_d;
      bbufread_q <= bbufread_d;
      res_we_q   <= res_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Dimension, loop-counter, base and address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d0_q      <= {n{1'b0}};
      d1_q      <= {n{1'b0}};
      d2_q      <= {n{1'b0}};
      i_q       <= {n{1'b0}};
      j_q       <= {n{1'b0}};
      k_q       <= {n{1'b0}};
      abase_q   <= {m{1'b0}};
      aadr_q    <= {m{1'b0}};
      badr_q    <= {m{1'b0}};
      res_adr_q <= {m{1'b0}};
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Clearing everything here makes CHECK start from element (0,0)
          // and keeps all address outputs at zero until the first CLEAR.
          if (start) begin
            d0_q      <= d0;
            d1_q      <= d1;
            d2_q      <= d2;
            i_q       <= {n{1'b0}};
            j_q       <= {n{1'b0}};
            k_q       <= {n{1'b0}};
            abase_q   <= {m{1'b0}};
            aadr_q    <= {m{1'b0}};
            badr_q    <= {m{1'b0}};
            res_adr_q <= {m{1'b0}};
            err_q     <= 1'b0;
          end
        end
        S_CHECK: begin
          if (ovf_s) err_q <= 1'b1;
        end
        S_MAC: begin
          aadr_q <= aadr_q + ONE_M;
          badr_q <= badr_q + d2_m_s;
          k_q    <= k_q + ONE_N;
        end
        S_WRITE: begin
          // Preload the next element's start addresses so CLEAR already shows them.
          res_adr_q <= res_adr_q + ONE_M;
          k_q       <= {n{1'b0}};
          if (more_col_s) begin
            j_q    <= j_q + ONE_N;
            aadr_q <= abase_q;
            badr_q <= j_q[m-1:0] + ONE_M;
          end else if (more_row_s) begin
            j_q     <= {n{1'b0}};
            i_q     <= i_q + ONE_N;
            abase_q <= abase_q + d1_m_s;
            aadr_q  <= abase_q + d1_m_s;
            badr_q  <= {m{1'b0}};
          end
        end
        default: begin
          err_q <= err_q;
        end
      endcase
    end
  end

  assign loaddim  = loaddim_q;
  assign init0reg = init0reg_q;
  assign ldreg    = ldreg_q;
  assign abufread = abufread_q;
  assign bbufread = bbufread_q;
  assign aadr     = aadr_q;
  assign badr     = badr_q;
  assign res_we   = res_we_q;
  assign res_adr  = res_adr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Testbench for matmul_ctrl.
// A per-job model pushes expected read and write addresses into queues; a
// negedge monitor pops them as the DUT issues reads and writes.
module tb_matmul_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] d0, d1, d2;
  logic       loaddim, init0reg, ldreg, abufread, bbufread;
  logic [3:0] aadr, badr, res_adr;
  logic       res_we, busy, done, err;

  int vectors     = 0;
  int miscompares = 0;
  int rq[$];
  int wq[$];
  int exp_writes  = 0;
  int cyc         = 0;
  int last_we     = 0;
  bit prev_abuf   = 1'b0;
  bit seen_init   = 1'b0;

  matmul_ctrl #(.n(8), .m(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .d0(d0), .d1(d1), .d2(d2),
    .loaddim(loaddim), .init0reg(init0reg), .ldreg(ldreg),
    .abufread(abufread), .bbufread(bbufread),
    .aadr(aadr), .badr(badr),
    .res_we(res_we), .res_adr(res_adr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int all_outs();
    return int'({loaddim, init0reg, ldreg, abufread, bbufread, aadr, badr,
                 res_we, res_adr, busy, done, err});
  endfunction

  // Push the expected read/write address streams for one job.
  // Returns the expected busy cycle count and error flag.
  task automatic push_exp(input int a, input int b, input int c,
                          output int exp_busy, output int exp_err);
    int ovf, zero;
    ovf  = ((a * b) > 16) || ((b * c) > 16) || ((a * c) > 16);
    zero = (a == 0) || (c == 0);
    exp_err    = ovf;
    exp_writes = 0;
    if (ovf || zero) begin
      exp_busy = 3;
    end else begin
      for (int i = 0; i < a; i++) begin
        for (int j = 0; j < c; j++) begin
          for (int k = 0; k < b; k++)
            rq.push_back(((i * b + k) % 16) * 16 + ((k * c + j) % 16));
          wq.push_back((i * c + j) % 16);
          exp_writes++;
        end
      end
      exp_busy = a * c * ((b == 0) ? 2 : (b + 3)) + 3;
    end
  endtask

  task automatic pulse_start(input int a, input int b, input int c);
    @(posedge clk); #1;
    d0 = 8'(a); d1 = 8'(b); d2 = 8'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int a, input int b, input int c, input bit midstart);
    int exp_busy, exp_err, busy_cnt, cyc_n;
    bit seen_done;
    push_exp(a, b, c, exp_busy, exp_err);
    pulse_start(a, b, c);
    @(negedge clk);
    check_eq("loaddim", int'(loaddim), 1);
    check_eq("err_cleared_on_start", int'(err), 0);
    busy_cnt  = int'(busy);
    seen_done = 1'b0;
    cyc_n     = 0;
    while (!seen_done && cyc_n < 4000) begin
      @(negedge clk);
      cyc_n++;
      if (busy) busy_cnt++;
      if (done) seen_done = 1'b1;
      // Hammer start while the MAC runs; the DUT must ignore it.
      start = midstart && abufread;
    end
    start = 1'b0;
    check_eq("done_seen", int'(seen_done), 1);
    check_eq("busy_cycles", busy_cnt, exp_busy);
    @(negedge clk);
    check_eq("done_one_cycle", int'(done), 0);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("err", int'(err), exp_err);
    repeat (2) @(negedge clk);
    check_eq("err_sticky", int'(err), exp_err);
    check_eq("reads_left", rq.size(), 0);
    check_eq("writes_left", wq.size(), 0);
  endtask

  // Scoreboard monitor: compares every read and write against the queues.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_abuf = 1'b0;
        seen_init = 1'b0;
      end else begin
        if (abufread || ldreg || prev_abuf)
          check_eq("ldreg_follows_read", int'(ldreg), int'(prev_abuf));
        if (abufread || bbufread) begin
          check_eq("bbufread", int'(bbufread), int'(abufread));
          if (rq.size() == 0) check_eq("read_unexpected", 1, 0);
          else check_eq("read_adr(a*16+b)", int'(aadr) * 16 + int'(badr), rq.pop_front());
        end
        if (init0reg) seen_init = 1'b1;
        if (res_we) begin
          check_eq("init_before_write", int'(seen_init), 1);
          seen_init = 1'b0;
          last_we   = cyc;
          if (wq.size() == 0) check_eq("write_unexpected", 1, 0);
          else check_eq("res_adr", int'(res_adr), wq.pop_front());
        end
        if (done && exp_writes > 0)
          check_eq("done_after_last_write", cyc - last_we, 1);
        prev_abuf = abufread;
      end
    end
  end

  initial begin
    int eb, ee, n_wait;
    bit hit;
    rst = 1'b0; start = 1'b0; d0 = 8'd0; d1 = 8'd0; d2 = 8'd0;
    #12;
    check_eq("reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_outputs", all_outs(), 0);

    run_job(2, 3, 2, 1'b0);   // baseline 2x3 * 3x2
    run_job(1, 1, 1, 1'b0);   // single element
    run_job(2, 0, 2, 1'b0);   // empty inner dimension: zero-valued writes
    run_job(5, 4, 1, 1'b0);   // d0*d1 overflow
    run_job(0, 3, 2, 1'b0);   // d0 == 0
    run_job(2, 5, 0, 1'b0);   // d2 == 0
    run_job(4, 4, 4, 1'b0);   // products exactly 16
    run_job(1, 16, 1, 1'b0);  // longest legal MAC
    run_job(1, 17, 1, 1'b0);  // d0*d1 and d1*d2 just over
    run_job(1, 2, 9, 1'b0);   // d1*d2 overflow only
    run_job(2, 3, 2, 1'b1);   // start pulsed during MAC

    // Asynchronous reset in the middle of element (1,0).
    push_exp(2, 3, 2, eb, ee);
    pulse_start(2, 3, 2);
    hit = 1'b0;
    n_wait = 0;
    while (!hit && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
      if (abufread && aadr == 4'd4) hit = 1'b1;
    end
    check_eq("reached_mid_mac", int'(hit), 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_eq("async_reset_outputs", all_outs(), 0);
    rq.delete();
    wq.delete();
    exp_writes = 0;
    repeat (3) @(negedge clk);
    check_eq("in_reset_outputs", all_outs(), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_reset_outputs", all_outs(), 0);
    run_job(2, 3, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
